// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message sequencer and its helpers.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam word_t IV_H0 = 32'h6A09E667;
  localparam word_t IV_H1 = 32'hBB67AE85;
  localparam word_t IV_H2 = 32'h3C6EF372;
  localparam word_t IV_H3 = 32'hA54FF53A;
  localparam word_t IV_H4 = 32'h510E527F;
  localparam word_t IV_H5 = 32'h9B05688C;
  localparam word_t IV_H6 = 32'h1F83D9AB;
  localparam word_t IV_H7 = 32'h5BE0CD19;

  // H0 occupies the top word, matching the core and digest bus layout.
  localparam logic [255:0] SHA256_IV = {IV_H0, IV_H1, IV_H2, IV_H3,
                                        IV_H4, IV_H5, IV_H6, IV_H7};

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    ACCUM,
    DONE
  } seq_state_e;

endpackage

// File: rtl/sha256_digest_add.sv
// Feed-forward adder: eight independent 32-bit modular sums, no carry between words.
module sha256_digest_add
  import sha256_pkg::*;
(
  input  logic [255:0] h_in,
  input  logic [255:0] res_in,
  output logic [255:0] h_out
);

  for (genvar i = 0; i < 8; i++) begin : g_word
    word_t h_w;
    word_t r_w;
    assign h_w = h_in[i*32 +: 32];
    assign r_w = res_in[i*32 +: 32];
    assign h_out[i*32 +: 32] = h_w + r_w;
  end

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Drives the SHA-256 compression core chunk by chunk and accumulates the running hash.
// state | meaning
// IDLE  | ready for a chunk; latches chunk, last flag and current H on handshake
// START | one-cycle launch pulse to the core; arms the response timer
// WAIT  | waiting for core_done; aborts the message on timer expiry
// ACCUM | adds the core result into H; bumps the chunk counter
// DONE  | holds the final digest until the consumer takes it
module sha256_msg_sequencer
  import sha256_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [511:0]     in_chunk,
  input  logic             in_last,
  output logic             core_valid,
  output logic [511:0]     core_chunk,
  output logic [255:0]     core_hash_in,
  input  logic             core_done,
  input  logic [255:0]     core_hash_out,
  output logic [255:0]     digest,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic [CNT_W-1:0] chunk_count,
  output logic             timeout_err
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Down-counter expires on the last WAIT cycle, so the error flag lands
  // exactly TIMEOUT_CYCLES cycles after the launch pulse.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 2);

  seq_state_e       state_q, state_d;
  logic             active_q;
  logic [255:0]     h_q, h_d;
  logic [255:0]     res_q, res_d;
  logic             last_q, last_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tout_q, tout_d;
  logic [255:0]     digest_q, digest_d;
  logic [511:0]     chunk_q, chunk_d;
  logic [255:0]     hin_q, hin_d;
  logic [255:0]     h_sum;

  sha256_digest_add u_add (
    .h_in   (h_q),
    .res_in (res_q),
    .h_out  (h_sum)
  );

  assign in_ready     = active_q && (state_q == IDLE);
  assign core_valid   = (state_q == START);
  assign digest_valid = (state_q == DONE);
  assign core_chunk   = chunk_q;
  assign core_hash_in = hin_q;
  assign digest       = digest_q;
  assign chunk_count  = cnt_q;
  assign timeout_err  = tout_q;

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    res_d    = res_q;
    last_d   = last_q;
    tmr_d    = tmr_q;
    cnt_d    = cnt_q;
    tout_d   = tout_q;
    digest_d = digest_q;
    chunk_d  = chunk_q;
    hin_d    = hin_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          chunk_d = in_chunk;
          last_d  = in_last;
          hin_d   = h_q;
          state_d = START;
        end
      end
      START: begin
        tmr_d   = TMR_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          res_d   = core_hash_out;
          state_d = ACCUM;
        end else if (tmr_q == '0) begin
          tout_d  = 1'b1;
          h_d     = SHA256_IV;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ACCUM: begin
        h_d = h_sum;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (last_q) begin
          digest_d = h_sum;
          state_d  = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (digest_ready) begin
          h_d     = SHA256_IV;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      active_q <= 1'b0;
      h_q      <= SHA256_IV;
      res_q    <= '0;
      last_q   <= 1'b0;
      tmr_q    <= '0;
      cnt_q    <= '0;
      tout_q   <= 1'b0;
      digest_q <= '0;
      chunk_q  <= '0;
      hin_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      h_q      <= h_d;
      res_q    <= res_d;
      last_q   <= last_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      tout_q   <= tout_d;
      digest_q <= digest_d;
      chunk_q  <= chunk_d;
      hin_q    <= hin_d;
    end
  end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Scoreboard bench for sha256_msg_sequencer with a behavioural compression core.
module tb_sha256_msg_sequencer;

  localparam int CNT_W = 16;
  localparam int TC    = 128;
  localparam logic [255:0] IV = 256'h6A09E667BB67AE853C6EF372A54FF53A510E527F9B05688C1F83D9AB5BE0CD19;
  localparam logic [255:0] HELLO_DIG = 256'hB94D27B9934D3E08A52E52D7DA7DABFAC484EFE37A5380EE9088F7ACE2EFCDE9;
  localparam logic [255:0] NIST_DIG  = 256'h248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1;
  localparam logic [255:0] WRAP_DIG  = 256'h6A09E666BB67AE843C6EF371A54FF539510E527E9B05688B1F83D9AA5BE0CD18;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [511:0]     in_chunk;
  logic             in_last;
  logic             core_valid;
  logic [511:0]     core_chunk;
  logic [255:0]     core_hash_in;
  logic             core_done;
  logic [255:0]     core_hash_out;
  logic [255:0]     digest;
  logic             digest_valid;
  logic             digest_ready;
  logic [CNT_W-1:0] chunk_count;
  logic             timeout_err;

  always #5 clk = ~clk;

  sha256_msg_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_chunk     (in_chunk),
    .in_last      (in_last),
    .core_valid   (core_valid),
    .core_chunk   (core_chunk),
    .core_hash_in (core_hash_in),
    .core_done    (core_done),
    .core_hash_out(core_hash_out),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .chunk_count  (chunk_count),
    .timeout_err  (timeout_err)
  );

  typedef struct { logic [511:0] chunk; logic last; int cyc; } acc_t;
  typedef struct { logic [255:0] dig; int cnt; } exp_t;

  acc_t        acc_q[$];
  exp_t        exp_q[$];
  logic [31:0] mdl_h [8];
  int          mdl_cnt;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          core_mode = 0;   // 0 real SHA-256, 1 random, 2 all-ones, 3 silent
  bit          auto_ready = 1'b0;
  int          launches = 0;
  int          launch_cyc = 0;
  logic        prev_cv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One SHA-256 compression without the final feed-forward.
  function automatic logic [255:0] compress(input logic [511:0] blk, input logic [255:0] hin);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a, b, c, d, e, f, g, h};
  endfunction

  function automatic logic [255:0] pack_h();
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[255-32*i -: 32] = mdl_h[i];
    return p;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 8; i++) mdl_h[i] = IV[255-32*i -: 32];
    mdl_cnt = 0;
  endtask

  function automatic logic [511:0] rand_chunk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  initial begin : core_stub
    acc_t a;
    logic [255:0] res;
    int lat;
    core_done = 1'b0;
    core_hash_out = '0;
    forever begin
      @(negedge clk);
      if (core_valid) begin
        launches++;
        launch_cyc = cyc;
        if (acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL launch_without_accept: core_valid seen at cycle %0d, required none", cyc);
        end else begin
          a = acc_q.pop_front();
          chk("launch_latency", 256'(cyc - a.cyc), 256'd1);
          chk("core_chunk", core_chunk, a.chunk);
          chk("core_hash_in", core_hash_in, pack_h());
          if (core_mode != 3) begin
            case (core_mode)
              0:       res = compress(a.chunk, pack_h());
              1:       for (int i = 0; i < 8; i++) res[32*i +: 32] = $urandom();
              default: res = '1;
            endcase
            lat = $urandom_range(1, 6);
            repeat (lat) @(posedge clk);
            #1;
            core_done = 1'b1;
            core_hash_out = res;
            @(posedge clk);
            #1;
            core_done = 1'b0;
            for (int i = 0; i < 8; i++) mdl_h[i] = mdl_h[i] + res[255-32*i -: 32];
            mdl_cnt++;
            if (a.last) begin
              exp_q.push_back('{dig: pack_h(), cnt: mdl_cnt});
              mdl_reset();
            end
          end
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (core_valid) chk("core_valid_single_pulse", {255'd0, prev_cv}, 256'd0);
      prev_cv = core_valid;
      if (digest_valid && digest_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_digest: got %0h, required no digest", digest);
        end else begin
          e = exp_q.pop_front();
          chk("sb_digest", digest, e.dig);
          chk("sb_chunk_count", 256'(chunk_count), 256'(e.cnt));
        end
      end
    end
  end

  initial begin : consumer
    forever begin
      @(posedge clk);
      #1;
      if (auto_ready) digest_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic send_chunk(input logic [511:0] ch, input logic last);
    int n;
    acc_t a;
    n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_chunk = ch;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end else begin
      a.chunk = ch;
      a.last  = last;
      a.cyc   = cyc;
      acc_q.push_back(a);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_chunk = rand_chunk();
    in_last  = $urandom_range(0, 1) != 0;
  endtask

  task automatic wait_digest(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!digest_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, {255'd0, digest_valid}, 256'd1);
  endtask

  task automatic finish_digest(input logic [255:0] exp, input string name);
    wait_digest(name);
    chk(name, digest, exp);
    @(posedge clk);
    #1;
    digest_ready = 1'b1;
    @(posedge clk);
    #1;
    digest_ready = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, {255'd0, in_ready}, 256'd1);
  endtask

  initial begin : main
    logic [87:0]  hw;
    logic [447:0] nist;
    logic [511:0] hello, n1, n2;
    logic [255:0] held;
    int n0, n, nch;
    hw    = "hello world";
    nist  = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    hello = {hw, 8'h80, 352'h0, 64'h58};
    n1    = {nist, 8'h80, 56'h0};
    n2    = {448'h0, 64'h1C0};

    in_valid = 1'b0;
    in_chunk = '0;
    in_last = 1'b0;
    digest_ready = 1'b0;
    mdl_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", {255'd0, in_ready}, 256'd0);
    chk("rst_core_valid", {255'd0, core_valid}, 256'd0);
    chk("rst_digest_valid", {255'd0, digest_valid}, 256'd0);
    chk("rst_chunk_count", 256'(chunk_count), 256'd0);
    chk("rst_digest", digest, 256'd0);
    chk("rst_core_hash_in", core_hash_in, 256'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", {255'd0, in_ready}, 256'd1);

    // single-chunk known vector
    core_mode = 0;
    n0 = launches;
    send_chunk(hello, 1'b1);
    finish_digest(HELLO_DIG, "hello_digest");
    chk("hello_launches", 256'(launches - n0), 256'd1);

    // two-chunk known vector
    send_chunk(n1, 1'b0);
    send_chunk(n2, 1'b1);
    finish_digest(NIST_DIG, "nist_digest");

    // per-word modular wrap
    core_mode = 2;
    send_chunk(rand_chunk(), 1'b1);
    finish_digest(WRAP_DIG, "wrap_digest");

    // digest backpressure
    core_mode = 0;
    send_chunk(hello, 1'b1);
    wait_digest("bp");
    held = digest;
    chk("bp_digest_value", held, HELLO_DIG);
    repeat (5) begin
      @(negedge clk);
      chk("bp_digest_valid_held", {255'd0, digest_valid}, 256'd1);
      chk("bp_digest_stable", digest, held);
      chk("bp_in_ready_low", {255'd0, in_ready}, 256'd0);
    end
    @(posedge clk);
    #1;
    digest_ready = 1'b1;
    @(posedge clk);
    #1;
    digest_ready = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_after", {255'd0, in_ready}, 256'd1);
    chk("bp_digest_valid_after", {255'd0, digest_valid}, 256'd0);
    chk("bp_chunk_count_after", 256'(chunk_count), 256'd0);
    send_chunk(n1, 1'b0);
    @(negedge clk);
    chk("bp_new_msg_iv", core_hash_in, IV);
    send_chunk(n2, 1'b1);
    finish_digest(NIST_DIG, "bp_nist_digest");

    // randomized traffic with random core results and random backpressure
    core_mode = 1;
    auto_ready = 1'b1;
    for (int m = 0; m < 20; m++) begin
      nch = $urandom_range(1, 3);
      for (int c = 0; c < nch; c++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        send_chunk(rand_chunk(), c == nch - 1);
      end
    end
    n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && acc_q.size() == 0 && in_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("random_drained", 256'(exp_q.size() + acc_q.size()), 256'd0);
    auto_ready = 1'b0;
    @(posedge clk);
    #1;
    digest_ready = 1'b0;

    // core timeout mid-message
    core_mode = 0;
    send_chunk(n1, 1'b0);
    wait_idle("to_first_chunk_idle");
    core_mode = 3;
    send_chunk(hello, 1'b1);
    n = 0;
    @(negedge clk);
    while (!timeout_err && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("to_flag", {255'd0, timeout_err}, 256'd1);
    chk("to_latency", 256'(cyc - launch_cyc), 256'(TC));
    chk("to_in_ready", {255'd0, in_ready}, 256'd1);
    chk("to_chunk_count", 256'(chunk_count), 256'd0);
    mdl_reset();
    @(posedge clk);
    #1;
    core_done = 1'b1;
    core_hash_out = '1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    @(negedge clk);
    chk("late_done_in_ready", {255'd0, in_ready}, 256'd1);
    chk("late_done_no_launch", {255'd0, core_valid}, 256'd0);
    core_mode = 0;
    send_chunk(hello, 1'b1);
    finish_digest(HELLO_DIG, "to_recover_digest");
    chk("to_sticky", {255'd0, timeout_err}, 256'd1);

    // asynchronous reset while waiting on the core
    core_mode = 3;
    send_chunk(hello, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {255'd0, in_ready}, 256'd0);
    chk("mid_rst_timeout_err", {255'd0, timeout_err}, 256'd0);
    chk("mid_rst_digest", digest, 256'd0);
    chk("mid_rst_core_chunk", core_chunk, 512'd0);
    chk("mid_rst_core_hash_in", core_hash_in, 256'd0);
    chk("mid_rst_chunk_count", 256'(chunk_count), 256'd0);
    acc_q.delete();
    exp_q.delete();
    mdl_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_in_ready", {255'd0, in_ready}, 256'd1);
    chk("rel_chunk_count", 256'(chunk_count), 256'd0);
    @(posedge clk);
    #1;
    core_done = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    @(negedge clk);
    chk("spurious_done_in_ready", {255'd0, in_ready}, 256'd1);
    chk("spurious_done_digest_valid", {255'd0, digest_valid}, 256'd0);
    core_mode = 0;
    send_chunk(hello, 1'b1);
    finish_digest(HELLO_DIG, "post_rst_digest");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sequencer.md
Name: sha256_msg_sequencer

Overview:
- Sequences the SHA-256 compression core over a multi-chunk message of pre-padded 512-bit chunks.
- Accepts chunks over a valid/ready stream and keeps the running hash state H0..H7.
- For each chunk it launches the core, waits for the result, and adds the result into H. On the last chunk it presents the final 256-bit digest.
- Sits between the preprocessing front end and the compression core.

Parameters:
- CNT_W, 16: width of the chunk counter.
- TIMEOUT_CYCLES, 128: cycles allowed from core launch to core_done before the job is aborted.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  chunk offered.
- in_ready  out  1  sequencer can accept a chunk.
- in_chunk  in  512  pre-padded chunk; bit 511 is the first message bit.
- in_last  in  1  chunk is the final chunk of its message.
- core_valid  out  1  one-cycle launch pulse to the core.
- core_chunk  out  512  chunk presented to the core; held stable from launch until core_done.
- core_hash_in  out  256  working-variable init (current H); H0 in bits 255:224.
- core_done  in  1  one-cycle pulse; core_hash_out is valid in this cycle.
- core_hash_out  in  256  compressed a..h without feed-forward; a in bits 255:224.
- digest  out  256  final hash; H0 in bits 255:224.
- digest_valid  out  1  digest available.
- digest_ready  in  1  consumer takes the digest.
- chunk_count  out  CNT_W  chunks completed in the current message.
- timeout_err  out  1  sticky; core failed to respond.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE and H is set to the IV.
  - core_valid, digest_valid, timeout_err and chunk_count are 0; digest, core_chunk and core_hash_in are 0.
  - in_ready is 0 while reset_n is low.
- in_ready equals (state == IDLE) and is registered-state driven only.
- IDLE: on in_valid && in_ready, latch in_chunk into core_chunk, in_last into last_q, and H into core_hash_in, then go to START. in_chunk is not sampled at any other time.
- START: core_valid = 1 for exactly this cycle; clear the timer; go to WAIT.
- WAIT:
  - If core_done: capture core_hash_out into res_q and go to ACCUM.
  - Otherwise increment the timer. When the timer reaches TIMEOUT_CYCLES-1 without core_done: set timeout_err=1, set H to the IV, set chunk_count to 0, and go to IDLE.
- core_done outside WAIT is ignored; no state change.
- ACCUM:
  - For i=0..7, H[i] <= H[i] + res_q[i] mod 2^32. There is no carry between words.
  - chunk_count increments and saturates at all-ones.
  - If last_q: digest <= the summed H, digest_valid <= 1, go to DONE. Otherwise go to IDLE.
- DONE:
  - digest_valid stays high and digest stays stable; in_ready=0.
  - On digest_ready: digest_valid <= 0, H <= IV, chunk_count <= 0, go to IDLE.
- Latency:
  - Chunk accepted in cycle t → core_valid in cycle t+1.
  - core_done in cycle k → digest_valid (last chunk) or in_ready (other chunks) in cycle k+2.
- timeout_err is cleared only by reset. Traffic continues after a timeout; the next accepted chunk starts a new message from the IV.
- in_valid while not in IDLE is ignored; the source must hold the chunk until the handshake completes.
- If reset_n asserts mid-job, the job is discarded with no partial digest, and all state returns to reset values immediately.

Decomposition:
- sha256_pkg holds:
  - word_t (logic [31:0]);
  - IV constants 6A09E667 BB67AE85 3C6EF372 A54FF53A 510E527F 9B05688C 1F83D9AB 5BE0CD19, also packed as SHA256_IV[255:0];
  - the state enum {IDLE, START, WAIT, ACCUM, DONE}.
- Sub-module sha256_digest_add: combinational, 8 parallel 32-bit modular adders (h_in, res_in → h_out). It is shared with future multi-core variants.

Test Plan:
- Single chunk: "hello world" padded (68656C6C6F20776F726C6480…0058), in_last=1, behavioural core → digest B94D27B9934D3E08A52E52D7DA7DABFAC484EFE37A5380EE9088F7ACE2EFCDE9, chunk_count=1, core_valid exactly 1 pulse.
- Two-chunk NIST vector "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" → digest 248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1. Check core_hash_in of the second launch equals H after chunk 1.
- Wrap arithmetic: stub core returns FFFFFFFF in all words for one last chunk → digest 6A09E666 BB67AE84 3C6EF371 A54FF539 510E527E 9B05688B 1F83D9AA 5BE0CD18.
- Backpressure: digest_ready low for 5 cycles → digest_valid and digest are held and in_ready=0. On handshake, in_ready=1 the next cycle, and a new message starts from the IV (core_hash_in = SHA256_IV).
- Timeout: stub core never pulses done → timeout_err=1 exactly TIMEOUT_CYCLES cycles after core_valid, state returns to IDLE, a late core_done is ignored, and a subsequent "hello world" still yields the correct digest.
- Reset mid-WAIT: assert reset_n=0 asynchronously between clock edges → all outputs read 0 immediately. After release, in_ready=1, chunk_count=0, and a spurious core_done has no effect.
